// File: rtl/module_teclado_scan.sv
// Matrix keypad scanner: drives one-hot columns, synchronises and debounces
// the rows, decodes a single key per press and queues the codes in a small
// FIFO with a valid/acknowledge handshake towards the consumer.
module module_teclado_scan #(
    parameter int N_FILAS    = 4,
    parameter int N_COLS     = 4,
    parameter int HEX_MAP    = 1,
    parameter int SCAN_DIV   = 27000,
    parameter int DEB_CNT    = 270000,
    parameter int FIFO_DEPTH = 4,
    localparam int CODE_W    = (HEX_MAP == 1) ? 4 : $clog2(N_FILAS * N_COLS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FILAS-1:0]  fila,
    output logic [N_COLS-1:0]   col,
    output logic [CODE_W-1:0]   num,
    output logic                rdy,
    input  logic                ack,
    output logic                tecla,
    output logic                ovf
);

    localparam int CI_W  = $clog2(N_COLS);
    localparam int RI_W  = $clog2(N_FILAS);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEB_CNT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        st_scan,
        st_debounce,
        st_held,
        st_release
    } state_t;

    // Standard 4x4 legend, row-major: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    function automatic logic [3:0] hex_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h2;
            4'd2:  code = 4'h3;
            4'd3:  code = 4'hA;
            4'd4:  code = 4'h4;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h6;
            4'd7:  code = 4'hB;
            4'd8:  code = 4'h7;
            4'd9:  code = 4'h8;
            4'd10: code = 4'h9;
            4'd11: code = 4'hC;
            4'd12: code = 4'hE;
            4'd13: code = 4'h0;
            4'd14: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [N_FILAS-1:0] fila_meta_reg;
    logic [N_FILAS-1:0] fs_reg;

    state_t             state_reg, state_next;
    logic [CI_W-1:0]    col_idx_reg, col_idx_next;
    logic [CI_W-1:0]    col_idx_adv;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [DEB_W-1:0]   deb_reg, deb_next;
    logic [N_FILAS-1:0] cap_reg, cap_next;
    logic               tecla_reg, tecla_next;

    logic [N_FILAS-1:0] fs_minus1;
    logic               fs_onehot;
    logic               div_last;
    logic               deb_last;
    logic [RI_W-1:0]    row_idx;
    logic               push;
    logic [CODE_W-1:0]  push_code;

    logic [CODE_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg, count_next, count_after_pop;
    logic [CODE_W-1:0]  num_reg, head_next;
    logic               rdy_reg, ovf_reg;
    logic               pop, full, accept, drop;

    // Two-flop synchroniser for the asynchronous row pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fila_meta_reg <= '0;
            fs_reg        <= '0;
        end else begin
            fila_meta_reg <= fila;
            fs_reg        <= fila_meta_reg;
        end
    end

    // One-hot column drive from the current column index
    for (genvar gi = 0; gi < N_COLS; gi++) begin : g_col
        assign col[gi] = (col_idx_reg == CI_W'(gi));
    end

    assign fs_minus1   = fs_reg - N_FILAS'(1);
    assign fs_onehot   = (fs_reg != '0) && ((fs_reg & fs_minus1) == '0);
    assign div_last    = (div_reg == DIV_W'(SCAN_DIV - 1));
    assign deb_last    = (deb_reg == DEB_W'(DEB_CNT - 1));
    assign col_idx_adv = (col_idx_reg == CI_W'(N_COLS - 1)) ? '0 : col_idx_reg + CI_W'(1);

    // Encode the captured row and build the key code for the current column
    always_comb begin
        int lin;
        row_idx = '0;
        for (int i = 0; i < N_FILAS; i++) begin
            if (cap_reg[i]) begin
                row_idx = RI_W'(i);
            end
        end
        lin = int'(row_idx) * N_COLS + int'(col_idx_reg);
        if (HEX_MAP == 1) begin
            push_code = CODE_W'(hex_code(4'(lin)));
        end else begin
            push_code = CODE_W'(lin);
        end
    end

    // Scanner state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= st_scan;
            col_idx_reg <= '0;
            div_reg     <= '0;
            deb_reg     <= '0;
            cap_reg     <= '0;
            tecla_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            col_idx_reg <= col_idx_next;
            div_reg     <= div_next;
            deb_reg     <= deb_next;
            cap_reg     <= cap_next;
            tecla_reg   <= tecla_next;
        end
    end

    // Scanner next-state: column stepping, press/release debounce, code push
    always_comb begin
        state_next   = state_reg;
        col_idx_next = col_idx_reg;
        div_next     = div_reg;
        deb_next     = deb_reg;
        cap_next     = cap_reg;
        tecla_next   = tecla_reg;
        push         = 1'b0;
        case (state_reg)
            st_scan: begin
                if (div_last) begin
                    div_next = '0;
                    if (fs_onehot) begin
                        // Column stays frozen while this key is qualified
                        cap_next   = fs_reg;
                        deb_next   = '0;
                        state_next = st_debounce;
                    end else begin
                        col_idx_next = col_idx_adv;
                    end
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            st_debounce: begin
                if (fs_reg != cap_reg) begin
                    col_idx_next = col_idx_adv;
                    div_next     = '0;
                    state_next   = st_scan;
                end else if (deb_last) begin
                    push       = 1'b1;
                    tecla_next = 1'b1;
                    state_next = st_held;
                end else begin
                    deb_next = deb_reg + DEB_W'(1);
                end
            end
            st_held: begin
                if (fs_reg == '0) begin
                    deb_next   = '0;
                    state_next = st_release;
                end
            end
            default: begin
                if (fs_reg != '0) begin
                    state_next = st_held;
                end else if (deb_last) begin
                    tecla_next   = 1'b0;
                    col_idx_next = col_idx_adv;
                    div_next     = '0;
                    state_next   = st_scan;
                end else begin
                    deb_next = deb_reg + DEB_W'(1);
                end
            end
        endcase
    end

    // FIFO control: a pop only counts while an entry is presented, and a
    // simultaneous pop frees the slot for a push into a full queue.
    assign pop             = ack & rdy_reg;
    assign full            = (count_reg == CNT_W'(FIFO_DEPTH));
    assign accept          = push & (~full | pop);
    assign drop            = push & full & ~pop;
    assign count_after_pop = count_reg - CNT_W'(pop);
    assign count_next      = count_after_pop + CNT_W'(accept);

    // Next head: bypass the pushed code when the queue would otherwise be empty
    always_comb begin
        head_next = num_reg;
        if (count_after_pop == '0) begin
            head_next = push_code;
        end else begin
            head_next = mem[rd_ptr_reg + PTR_W'(pop)];
        end
    end

    // Queue storage, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= push_code;
        end
    end

    // Queue pointers, occupancy and registered head/valid/overflow outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            num_reg    <= '0;
            rdy_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
            count_reg  <= count_next;
            rdy_reg    <= (count_next != '0);
            if (count_next != '0) begin
                num_reg <= head_next;
            end
            ovf_reg <= drop;
        end
    end

    assign num   = num_reg;
    assign rdy   = rdy_reg;
    assign tecla = tecla_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_module_teclado_scan.sv
// Bench for module_teclado_scan: keypad model driven by the column outputs,
// expected codes queued on each press, popped and compared by a monitor.
module tb_module_teclado_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] fila;
    logic [3:0] col;
    logic [3:0] num;
    logic       rdy, ack, tecla, ovf;

    logic [2:0] fila2;
    logic [4:0] col2;
    logic [3:0] num2;
    logic       rdy2, tecla2, ovf2;
    logic       ack2;

    always #5 clk = ~clk;

    module_teclado_scan #(
        .N_FILAS(4), .N_COLS(4), .HEX_MAP(1),
        .SCAN_DIV(4), .DEB_CNT(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fila(fila), .col(col), .num(num),
        .rdy(rdy), .ack(ack), .tecla(tecla), .ovf(ovf)
    );

    module_teclado_scan #(
        .N_FILAS(3), .N_COLS(5), .HEX_MAP(0),
        .SCAN_DIV(4), .DEB_CNT(3), .FIFO_DEPTH(4)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .fila(fila2), .col(col2), .num(num2),
        .rdy(rdy2), .ack(ack2), .tecla(tecla2), .ovf(ovf2)
    );

    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   ovf_cnt = 0;
    logic ovf_prev = 1'b0;
    int   hexmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    int   fmode;      // 0 keypad model, 1 ghost pair on col0, 2 all rows high
    logic key_on;
    int   pr, pc;
    logic key2_on;
    logic ack_mode;   // 1: random consumer acknowledges

    // Physical keypad: a closed key connects its column drive to its row
    always_comb begin
        case (fmode)
            1:       fila = col[0] ? 4'b0011 : 4'b0000;
            2:       fila = 4'b1111;
            default: fila = (key_on && col[pc]) ? 4'(1 << pr) : 4'b0000;
        endcase
        fila2 = (key2_on && col2[4]) ? 3'b100 : 3'b000;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Random consumer: changes ack just after the rising edge
    always @(posedge clk) begin
        #2;
        if (ack_mode) ack = 1'($urandom_range(0, 1));
    end

    // Monitor: every pop is compared against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            if (ovf) begin
                ovf_cnt++;
                chk("ovf_width", int'(ovf_prev), 0);
            end
            ovf_prev = ovf;
            if (rdy && ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_code actual=%0d required=none", num);
                end else begin
                    chk("code", int'(num), exp_q.pop_front());
                end
            end
        end else begin
            ovf_prev = 1'b0;
        end
    end

    task automatic wait_tecla(input logic v, input string name);
        bit got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (tecla == v) got = 1;
        end
        chk(name, int'(got), 1);
    endtask

    task automatic wait_col(input logic [3:0] v);
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (col == v) got = 1;
        end
        chk("wait_col", int'(got), 1);
    endtask

    task automatic press(input int r, input int c, input bit expect_code);
        pr = r;
        pc = c;
        if (expect_code) exp_q.push_back(hexmap[r * 4 + c]);
        key_on = 1'b1;
        wait_tecla(1'b1, "press_tecla");
    endtask

    task automatic release_key();
        key_on = 1'b0;
        wait_tecla(1'b0, "release_tecla");
        repeat (3) @(negedge clk);
    endtask

    task automatic drain();
        ack_mode = 1'b1;
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        ack_mode = 1'b0;
        ack = 1'b0;
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_rdy", int'(rdy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ovf0;
        bit got2;
        rst_n = 1'b0; fmode = 2; key_on = 1'b0; key2_on = 1'b0;
        ack = 1'b0; ack2 = 1'b0; ack_mode = 1'b0; pr = 0; pc = 0;

        // Reset with all rows asserted
        repeat (3) @(negedge clk);
        chk("rst_col", int'(col), 1);
        chk("rst_rdy", int'(rdy), 0);
        chk("rst_tecla", int'(tecla), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_num", int'(num), 0);
        chk("rst_col2", int'(col2), 1);
        fmode = 0;
        rst_n = 1'b1;

        // Every key in legend order
        ack_mode = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                press(r, c, 1'b1);
                release_key();
            end
        end
        drain();

        // Random single presses
        ack_mode = 1'b1;
        repeat (8) begin
            press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
            release_key();
        end
        drain();

        // Contact bounce on row0/col1, then a glitch during release
        ack_mode = 1'b1;
        pr = 0; pc = 1;
        exp_q.push_back(2);
        key_on = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_on = ~key_on;
            @(negedge clk);
        end
        key_on = 1'b1;
        wait_tecla(1'b1, "bounce_tecla");
        key_on = 1'b0;
        repeat (3) @(negedge clk);
        key_on = 1'b1;
        @(negedge clk);
        key_on = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_tecla_n8", int'(tecla), 1);
        @(negedge clk);
        chk("glitch_tecla_n9", int'(tecla), 1);
        @(negedge clk);
        chk("glitch_tecla_n10", int'(tecla), 0);
        repeat (3) @(negedge clk);
        drain();

        // Ghosting: two rows on column 0 must be skipped on schedule
        wait_col(4'b1000);
        fmode = 1;
        wait_col(4'b0001);
        repeat (3) @(negedge clk);
        chk("ghost_col_hold", int'(col), 1);
        @(negedge clk);
        chk("ghost_col_next", int'(col), 2);
        chk("ghost_rdy", int'(rdy), 0);
        chk("ghost_tecla", int'(tecla), 0);
        fmode = 0;

        // FIFO full: fifth code dropped with a single ovf pulse
        ovf0 = ovf_cnt;
        for (int c = 0; c < 4; c++) begin
            press(0, c, 1'b1);
            release_key();
        end
        chk("full_rdy", int'(rdy), 1);
        chk("full_num", int'(num), 1);
        chk("full_no_ovf_yet", ovf_cnt, ovf0);
        press(1, 0, 1'b0);
        release_key();
        chk("full_ovf_once", ovf_cnt, ovf0 + 1);
        chk("full_num_hold", int'(num), 1);
        drain();

        // Push into a full FIFO on the same clock as a pop
        for (int c = 0; c < 4; c++) begin
            press(0, c, 1'b1);
            release_key();
        end
        ovf0 = ovf_cnt;
        pr = 1; pc = 3;
        wait_col(4'b0001);
        exp_q.push_back(11);
        key_on = 1'b1;
        wait_col(4'b1000);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 ack = 1'b1;
        @(posedge clk);
        #2 ack = 1'b0;
        @(negedge clk);
        chk("simul_push_tecla", int'(tecla), 1);
        chk("simul_head", int'(num), 2);
        release_key();
        chk("simul_no_ovf", ovf_cnt, ovf0);
        drain();

        // Reset while a key is held with two codes queued
        press(2, 0, 1'b1);
        release_key();
        press(2, 1, 1'b1);
        chk("mid_rdy_before", int'(rdy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rdy", int'(rdy), 0);
        chk("mid_rst_tecla", int'(tecla), 0);
        chk("mid_rst_col", int'(col), 1);
        exp_q.delete();
        exp_q.push_back(8);
        rst_n = 1'b1;
        wait_tecla(1'b1, "mid_fresh_tecla");
        release_key();
        drain();

        // Linear code on a 3x5 pad: row 2, column 4
        key2_on = 1'b1;
        got2 = 0;
        for (int i = 0; i < 400 && !got2; i++) begin
            @(negedge clk);
            if (tecla2) got2 = 1;
        end
        chk("lin_tecla2", int'(got2), 1);
        chk("lin_num2", int'(num2), 14);
        chk("lin_rdy2", int'(rdy2), 1);

        chk("ovf_total", ovf_cnt, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/module_teclado_scan.md
# module_teclado_scan

Parametrised keypad scanner that drives the keypad columns itself, synchronises and debounces the row inputs, and decodes one key press into a key code. It queues codes in a small FIFO and hands them to the consumer with a valid/acknowledge handshake. It sits between the physical matrix keypad pins and the input-capture logic. It also provides hex mapping for the standard 4x4 pad.

## Interface
- N_FILAS, 4: number of keypad rows (≥2).
- N_COLS, 4: number of keypad columns (≥2).
- HEX_MAP, 1: 1 = standard 4x4 hex legend; 0 = linear code. HEX_MAP=1 is legal only with 4x4.
- SCAN_DIV, 27000: clocks each column is driven (≥3).
- DEB_CNT, 270000: consecutive stable clocks required for press and for release (≥1).
- FIFO_DEPTH, 4: key-code queue depth (power of two, ≥2).
- CODE_W, derived: 4 if HEX_MAP=1, else $clog2(N_FILAS*N_COLS).
- clk in 1: system clock. The block has one clock.
- rst_n in 1: synchronous, active-low reset.
- fila in N_FILAS: asynchronous row inputs, active-high; bit r = row r.
- col out N_COLS: one-hot, active-high column drive.
- num out CODE_W: code at the FIFO head.
- rdy out 1: FIFO non-empty; num is valid.
- ack in 1: consumer pop. Acts only when rdy=1.
- tecla out 1: a debounced key is currently held.
- ovf out 1: one-clock pulse when a code is dropped because the FIFO is full.

## Operation
- fila passes through a 2-FF synchroniser. All decisions use the synchronised value fs.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN: col is one-hot at index c, and c advances every SCAN_DIV clocks (wraps N_COLS-1 → 0). fs is sampled on the last clock of each column period:
  - exactly one bit of fs set: capture (r,c), load the counter, and go to DEBOUNCE. col freezes.
  - zero bits or more than one bit set (ghosting): advance c and stay in SCAN.
- DEBOUNCE: each clock, compare fs with the captured one-hot.
  - mismatch: go to SCAN, advance c.
  - DEB_CNT consecutive matches: push the code, set tecla=1, go to HELD.
- HELD: col stays frozen. When fs == 0, reload the counter and go to RELEASE.
- RELEASE:
  - any fs ≠ 0: return to HELD.
  - DEB_CNT consecutive zero clocks: tecla=0, advance c, go to SCAN.
- Only one code is produced per press. There is no auto-repeat.
- Linear code = r*N_COLS + c.
- Hex map (row-major, r0..r3): 1,2,3,A / 4,5,6,B / 7,8,9,C / E(*),0,F(#),D.
- FIFO behaviour:
  - push when not full: accept.
  - push when full with no pop in the same cycle: drop the code and pulse ovf.
  - push and pop in the same cycle: both take effect, including when full or when empty.
  - ack while rdy=0: ignored.
- Reset values: col = one-hot bit 0; num = 0; rdy = 0; tecla = 0; ovf = 0; state SCAN; FIFO empty; synchroniser 0; counters 0.
- Reset mid-operation: all state is lost, including queued codes. Scanning restarts from column 0 on the first clock after rst_n rises.

## Timing
- fs lags fila by 2 clocks. SCAN_DIV ≥ 3 guarantees the sample sees the current column.
- Press latency: from the SCAN sample clock, DEB_CNT clocks in DEBOUNCE, then the push.
  - rdy and num update on the clock after the push; tecla rises on the same clock.
- num/rdy are registered FIFO outputs. num holds steady while rdy=1 and ack=0.
- A pop on clock k presents the next entry, or rdy=0, on clock k+1.
- ovf is high for exactly the clock after the rejected push.
- col changes only on SCAN column-period boundaries or when leaving RELEASE/DEBOUNCE. It never changes in HELD.

## Test plan
Bench parameters: SCAN_DIV=4, DEB_CNT=3, FIFO_DEPTH=4, 4x4, HEX_MAP=1, unless stated.
- Reset: hold rst_n=0 for 3 clocks with fila=4'b1111 -> col=0001, rdy=0, tecla=0, ovf=0, num=0. Check all 16 keys pressed and released one at a time -> codes 1,2,3,A,4,5,6,B,7,8,9,C,E,0,F,D in order, each with rdy=1.
- Bounce: with row0 col1 driven, toggle fila bit0 every clock for 10 clocks, then hold -> exactly one code 2. Release with a 1-clock glitch inside RELEASE -> tecla stays 1 until 3 clean zero clocks.
- Ghosting: fila=0011 while col0 is driven -> no push. Scanning continues and col reaches 0010 on schedule.
- FIFO full: 5 presses with ack=0 -> rdy=1, num=1. A single ovf pulse occurs on the 5th press. Four acks then return 1,2,3,A, and rdy=0 after the 4th.
- Simultaneous: FIFO full and ack asserted on the push clock -> no ovf, and the count stays 4.
- Reset mid-press: drop rst_n in HELD with 2 codes queued -> rdy=0, tecla=0, col=0001 on the next clock. Holding the key after reset yields a fresh code.
- HEX_MAP=0, 3x5 -> press r2,c4 gives num=14, CODE_W=4.
